id_ex_buffer: RTL and testbench
===============================

# id_ex_buffer

Decode-side reader of the IF/ID instruction buffer. Each cycle it consumes the buffered instruction and PC, decodes the 16-bit instruction into fields, controls and a sign-extended immediate, and registers them into the ID/EX stage. It detects load-use hazards against the instruction it currently holds, stalls fetch and inserts a bubble. It also honours the pipeline flush and enters a sticky halt state.

## Interface
- Parameters: none.
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- flush  input  1  squash ID/EX contents this edge (branch/jump taken).
- instructionBuffIn  input  16  instruction from IF/ID buffer.
- pcBuffIn  input  16  PC of that instruction.
- validIn  input  1  IF/ID entry holds a real instruction.
- stall  output  1  combinational; fetch and IF/ID must hold this cycle.
- halted  output  1  registered; core is halted.
- validOut  output  1  ID/EX entry is a real instruction (0 = bubble).
- opcodeOut  output  4  instr[15:12].
- op1Out  output  4  instr[11:8] (destination / first source).
- op2Out  output  4  instr[7:4] (second source / base).
- functOut  output  4  instr[3:0].
- immOut  output  16  decoded immediate.
- pcOut  output  16  PC of ID/EX instruction.
- memReadOut, memWriteOut, regWriteOut, branchOut, jumpOut  output  1 each  decoded controls.
- stallCount  output  16  number of hazard stalls since reset, saturating.

## Operation
- Opcodes: 0000 ALU (R-type, funct selects op); 1000 LW (op1 = rd, op2 = base, imm4 offset); 1011 SW (op1 = data, op2 = base); 0100/0101/0110 BEQ/BLT/BGT (compare op1 with R15, imm8 offset); 1100 JMP (imm12); 1111 HALT. All other opcodes decode as NOP: validOut=1, all controls 0.
- Controls:
  - regWrite = ALU or LW.
  - memRead = LW.
  - memWrite = SW.
  - branch = 0100/0101/0110.
  - jump = 1100.
- Immediate:
  - LW/SW: sext(instr[3:0]).
  - Branch: sext(instr[7:0]).
  - JMP: sext(instr[11:0]).
  - All others: zero-extended instr[3:0].
- Source usage:
  - op1 is read by ALU, SW, branches.
  - op2 is read by ALU, LW, SW.
  - JMP, HALT and NOP read none.
- Load-use hazard: the registered ID/EX entry has validOut=1, memReadOut=1 and op1Out≠0, and the incoming entry has validIn=1 and reads a source equal to op1Out. R0 never causes a hazard.
- State machine:
  - RUN: normal operation. On the decode of a valid HALT with no flush, the next state is HALTED.
  - HALTED: stall=1 and halted=1. Every edge loads a bubble. Only rst exits.
- Per-edge update priority, highest first:
  1. rst: ID/EX cleared, state RUN, stallCount=0.
  2. flush: load bubble. A flush overrides both a hazard and a HALT decode, so the state stays RUN.
  3. HALTED: load bubble.
  4. hazard: load bubble, stallCount+1, saturating at 0xFFFF.
  5. otherwise: load the decoded incoming entry. validOut = validIn.
- Bubble: validOut=0 and all controls 0. Fields, imm and pc are cleared to 0.

## Timing
- Decode-to-output latency is 1 cycle: outputs are registered.
- stall is combinational from the current ID/EX registers, the incoming instruction and the state:
  - stall = hazard & ~flush in RUN.
  - stall = 1 in HALTED.
- A load followed by a dependent instruction costs exactly 1 stall cycle. The bubble clears memReadOut, so stall drops on the next cycle and the held instruction is accepted.
- Reset values: every output is 0. stall is 0 after reset because validOut=0.
- Flush and hazard in the same cycle: stall=0 and a bubble is loaded. stallCount is not incremented.
- rst asserted while HALTED or mid-stall: the next edge returns to RUN with all outputs 0.

## Test plan
- Reset: rst=1 for 2 edges with arbitrary inputs -> all outputs 0 and stall=0. Release rst; feed ALU 0x0123 at pc 0x0002 -> next cycle opcodeOut=0, op1Out=1, op2Out=2, functOut=3, regWriteOut=1, validOut=1, pcOut=0x0002.
- Load-use: LW 0x8310 then ALU 0x0435 (reads R3) -> stall=1 for exactly one cycle, one bubble (validOut=0), ALU entry follows, stallCount=1.
- No hazard: LW 0x8010 (rd=R0) then ALU 0x0105 -> no stall. LW 0x8310 then JMP 0xC003 -> no stall.
- Immediates:
  - SW 0xB12F -> immOut=0xFFFF, memWriteOut=1.
  - BEQ 0x4080 -> immOut=0xFF80, branchOut=1.
  - JMP 0xC7FF -> immOut=0x07FF, jumpOut=1.
- Flush priority: flush=1 in the same cycle as a load-use hazard -> stall=0, bubble, stallCount unchanged. A flush coinciding with a HALT decode -> halted stays 0.
- Halt: HALT 0xF000 decoded -> next cycle halted=1 and stall=1, and these hold for 10 cycles with validOut=0 despite flush pulses. rst -> halted=0.

Source files
------------

// File: rtl/id_ex_buffer.sv
// ============================================================================
//  Module      : id_ex_buffer
//  Description : ID stage reader of the IF/ID buffer; decodes the 16-bit
//                instruction into the ID/EX register, handles load-use
//                stalls, flushes and a sticky halt.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module id_ex_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [15:0] instructionBuffIn,
    input  logic [15:0] pcBuffIn,
    input  logic        validIn,
    output logic        stall,
    output logic        halted,
    output logic        validOut,
    output logic [3:0]  opcodeOut,
    output logic [3:0]  op1Out,
    output logic [3:0]  op2Out,
    output logic [3:0]  functOut,
    output logic [15:0] immOut,
    output logic [15:0] pcOut,
    output logic        memReadOut,
    output logic        memWriteOut,
    output logic        regWriteOut,
    output logic        branchOut,
    output logic        jumpOut,
    output logic [15:0] stallCount
);

    localparam logic [3:0] OP_ALU  = 4'b0000;
    localparam logic [3:0] OP_LW   = 4'b1000;
    localparam logic [3:0] OP_SW   = 4'b1011;
    localparam logic [3:0] OP_BEQ  = 4'b0100;
    localparam logic [3:0] OP_BLT  = 4'b0101;
    localparam logic [3:0] OP_BGT  = 4'b0110;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [3:0]  opcode;
        logic [3:0]  op1;
        logic [3:0]  op2;
        logic [3:0]  funct;
        logic [15:0] imm;
        logic [15:0] pc;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        branch;
        logic        jump;
    } entry_t;

    state_t      state_q, state_d;
    entry_t      entry_q, entry_d;
    entry_t      dec;
    logic [15:0] cnt_q, cnt_d;
    logic        reads_op1;
    logic        reads_op2;
    logic        is_branch;
    logic        hazard;

    // Instruction decode of the incoming IF/ID entry
    always_comb begin
        dec           = '0;
        dec.valid     = validIn;
        dec.opcode    = instructionBuffIn[15:12];
        dec.op1       = instructionBuffIn[11:8];
        dec.op2       = instructionBuffIn[7:4];
        dec.funct     = instructionBuffIn[3:0];
        dec.pc        = pcBuffIn;
        is_branch     = (dec.opcode == OP_BEQ) || (dec.opcode == OP_BLT) ||
                        (dec.opcode == OP_BGT);
        dec.reg_write = (dec.opcode == OP_ALU) || (dec.opcode == OP_LW);
        dec.mem_read  = (dec.opcode == OP_LW);
        dec.mem_write = (dec.opcode == OP_SW);
        dec.branch    = is_branch;
        dec.jump      = (dec.opcode == OP_JMP);
        reads_op1     = (dec.opcode == OP_ALU) || (dec.opcode == OP_SW) || is_branch;
        reads_op2     = (dec.opcode == OP_ALU) || (dec.opcode == OP_LW) ||
                        (dec.opcode == OP_SW);
        if (dec.mem_read || dec.mem_write)
            dec.imm = {{12{instructionBuffIn[3]}}, instructionBuffIn[3:0]};
        else if (is_branch)
            dec.imm = {{8{instructionBuffIn[7]}}, instructionBuffIn[7:0]};
        else if (dec.jump)
            dec.imm = {{4{instructionBuffIn[11]}}, instructionBuffIn[11:0]};
        else
            dec.imm = {12'h000, instructionBuffIn[3:0]};
    end

    // R0 is hard-wired zero, so a load into it never creates a dependence
    assign hazard = entry_q.valid && entry_q.mem_read && (entry_q.op1 != 4'd0) &&
                    validIn &&
                    ((reads_op1 && (dec.op1 == entry_q.op1)) ||
                     (reads_op2 && (dec.op2 == entry_q.op1)));

    always_comb begin
        state_d = state_q;
        entry_d = dec;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        if (flush) begin
            entry_d = '0;
            stall   = (state_q == ST_HALTED);
        end else if (state_q == ST_HALTED) begin
            entry_d = '0;
            stall   = 1'b1;
        end else if (hazard) begin
            entry_d = '0;
            stall   = 1'b1;
            if (cnt_q != 16'hFFFF)
                cnt_d = cnt_q + 16'd1;
        end else if (validIn && (dec.opcode == OP_HALT)) begin
            state_d = ST_HALTED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            entry_q <= '0;
            cnt_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign halted      = (state_q == ST_HALTED);
    assign validOut    = entry_q.valid;
    assign opcodeOut   = entry_q.opcode;
    assign op1Out      = entry_q.op1;
    assign op2Out      = entry_q.op2;
    assign functOut    = entry_q.funct;
    assign immOut      = entry_q.imm;
    assign pcOut       = entry_q.pc;
    assign memReadOut  = entry_q.mem_read;
    assign memWriteOut = entry_q.mem_write;
    assign regWriteOut = entry_q.reg_write;
    assign branchOut   = entry_q.branch;
    assign jumpOut     = entry_q.jump;
    assign stallCount  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_buffer.sv
// ============================================================================
//  Module      : tb_id_ex_buffer
//  Description : Directed table-driven bench for id_ex_buffer.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_buffer;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [15:0] instructionBuffIn;
    logic [15:0] pcBuffIn;
    logic        validIn;
    logic        stall;
    logic        halted;
    logic        validOut;
    logic [3:0]  opcodeOut;
    logic [3:0]  op1Out;
    logic [3:0]  op2Out;
    logic [3:0]  functOut;
    logic [15:0] immOut;
    logic [15:0] pcOut;
    logic        memReadOut;
    logic        memWriteOut;
    logic        regWriteOut;
    logic        branchOut;
    logic        jumpOut;
    logic [15:0] stallCount;

    id_ex_buffer dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .instructionBuffIn (instructionBuffIn),
        .pcBuffIn          (pcBuffIn),
        .validIn           (validIn),
        .stall             (stall),
        .halted            (halted),
        .validOut          (validOut),
        .opcodeOut         (opcodeOut),
        .op1Out            (op1Out),
        .op2Out            (op2Out),
        .functOut          (functOut),
        .immOut            (immOut),
        .pcOut             (pcOut),
        .memReadOut        (memReadOut),
        .memWriteOut       (memWriteOut),
        .regWriteOut       (regWriteOut),
        .branchOut         (branchOut),
        .jumpOut           (jumpOut),
        .stallCount        (stallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl packing: {memRead, memWrite, regWrite, branch, jump}
    typedef struct {
        logic        rst, flush, vin;
        logic [15:0] instr, pc;
        logic        chk_stall, stall;
        logic        valid;
        logic [15:0] fields, imm, epc;
        logic [4:0]  ctl;
        logic        halt;
        logic [15:0] cnt;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   vidx   = 0;
    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic f, logic vi, logic [15:0] ins, logic [15:0] p,
                                logic cs, logic s, logic v, logic [15:0] fl, logic [15:0] im,
                                logic [15:0] ep, logic [4:0] c, logic h, logic [15:0] n);
        vec_t t;
        t.rst = r; t.flush = f; t.vin = vi; t.instr = ins; t.pc = p;
        t.chk_stall = cs; t.stall = s; t.valid = v; t.fields = fl; t.imm = im;
        t.epc = ep; t.ctl = c; t.halt = h; t.cnt = n;
        return t;
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %h expected %h", name, vidx, act, exp);
        end
    endtask

    task automatic apply(vec_t t);
        @(negedge clk);
        rst = t.rst; flush = t.flush; validIn = t.vin;
        instructionBuffIn = t.instr; pcBuffIn = t.pc;
        #1;
        if (t.chk_stall) check("stall", {15'd0, stall}, {15'd0, t.stall});
        @(posedge clk);
        #1;
        check("validOut", {15'd0, validOut}, {15'd0, t.valid});
        check("fields",   {opcodeOut, op1Out, op2Out, functOut}, t.fields);
        check("immOut",   immOut, t.imm);
        check("pcOut",    pcOut, t.epc);
        check("ctl", {11'd0, memReadOut, memWriteOut, regWriteOut, branchOut, jumpOut},
              {11'd0, t.ctl});
        check("halted",   {15'd0, halted}, {15'd0, t.halt});
        check("stallCount", stallCount, t.cnt);
        vidx++;
    endtask

    int na;

    initial begin
        rst = 1'b1; flush = 1'b0; validIn = 1'b0;
        instructionBuffIn = 16'h0; pcBuffIn = 16'h0;

        // Part A: reset, decode, load-use, immediates, flush, halt entry
        tbl.push_back(mk(1,1,1,16'h8310,16'h1234, 0,0, 0,16'h0000,16'h0000,16'h0000,5'b00000,0,0));
        tbl.push_back(mk(1,0,1,16'hF000,16'h5678, 1,0, 0,16'h0000,16'h0000,16'h0000,5'b00000,0,0));
        tbl.push_back(mk(0,0,1,16'h0123,16'h0002, 1,0, 1,16'h0123,16'h0003,16'h0002,5'b00100,0,0));
        tbl.push_back(mk(0,0,1,16'h8310,16'h0004, 1,0, 1,16'h8310,16'h0000,16'h0004,5'b10100,0,0));
        tbl.push_back(mk(0,0,1,16'h0435,16'h0006, 1,1, 0,16'h0000,16'h0000,16'h0000,5'b00000,0,1));
        tbl.push_back(mk(0,0,1,16'h0435,16'h0006, 1,0, 1,16'h0435,16'h0005,16'h0006,5'b00100,0,1));
        tbl.push_back(mk(0,0,1,16'h8010,16'h0008, 1,0, 1,16'h8010,16'h0000,16'h0008,5'b10100,0,1));
        tbl.push_back(mk(0,0,1,16'h0105,16'h000A, 1,0, 1,16'h0105,16'h0005,16'h000A,5'b00100,0,1));
        tbl.push_back(mk(0,0,1,16'h8310,16'h000C, 1,0, 1,16'h8310,16'h0000,16'h000C,5'b10100,0,1));
        tbl.push_back(mk(0,0,1,16'hC003,16'h000E, 1,0, 1,16'hC003,16'h0003,16'h000E,5'b00001,0,1));
        tbl.push_back(mk(0,0,1,16'hB12F,16'h0010, 1,0, 1,16'hB12F,16'hFFFF,16'h0010,5'b01000,0,1));
        tbl.push_back(mk(0,0,1,16'h4080,16'h0012, 1,0, 1,16'h4080,16'hFF80,16'h0012,5'b00010,0,1));
        tbl.push_back(mk(0,0,1,16'hC7FF,16'h0014, 1,0, 1,16'hC7FF,16'h07FF,16'h0014,5'b00001,0,1));
        tbl.push_back(mk(0,0,1,16'h8310,16'h0016, 1,0, 1,16'h8310,16'h0000,16'h0016,5'b10100,0,1));
        tbl.push_back(mk(0,1,1,16'h0435,16'h0018, 1,0, 0,16'h0000,16'h0000,16'h0000,5'b00000,0,1));
        tbl.push_back(mk(0,0,1,16'h8310,16'h001A, 1,0, 1,16'h8310,16'h0000,16'h001A,5'b10100,0,1));
        tbl.push_back(mk(0,1,1,16'hF000,16'h001C, 1,0, 0,16'h0000,16'h0000,16'h0000,5'b00000,0,1));
        tbl.push_back(mk(0,0,1,16'hF000,16'h0022, 1,0, 1,16'hF000,16'h0000,16'h0022,5'b00000,1,1));
        na = tbl.size();

        // Part B: reset from HALTED, NOP, branch/LW/SW dependences, reset mid-stall
        tbl.push_back(mk(1,0,1,16'h0435,16'h0024, 1,1, 0,16'h0000,16'h0000,16'h0000,5'b00000,0,0));
        tbl.push_back(mk(0,0,1,16'h2345,16'h0030, 1,0, 1,16'h2345,16'h0005,16'h0030,5'b00000,0,0));
        tbl.push_back(mk(0,0,1,16'h8310,16'h0032, 1,0, 1,16'h8310,16'h0000,16'h0032,5'b10100,0,0));
        tbl.push_back(mk(0,0,1,16'h63FE,16'h0034, 1,1, 0,16'h0000,16'h0000,16'h0000,5'b00000,0,1));
        tbl.push_back(mk(0,0,1,16'h63FE,16'h0034, 1,0, 1,16'h63FE,16'hFFFE,16'h0034,5'b00010,0,1));
        tbl.push_back(mk(0,0,1,16'h8710,16'h0036, 1,0, 1,16'h8710,16'h0000,16'h0036,5'b10100,0,1));
        tbl.push_back(mk(1,0,1,16'hB570,16'h0038, 1,1, 0,16'h0000,16'h0000,16'h0000,5'b00000,0,0));
        tbl.push_back(mk(0,0,1,16'h8710,16'h0040, 1,0, 1,16'h8710,16'h0000,16'h0040,5'b10100,0,0));
        tbl.push_back(mk(0,0,1,16'h8270,16'h0042, 1,1, 0,16'h0000,16'h0000,16'h0000,5'b00000,0,1));
        tbl.push_back(mk(0,0,1,16'h8270,16'h0042, 1,0, 1,16'h8270,16'h0000,16'h0042,5'b10100,0,1));

        for (int i = 0; i < na; i++) apply(tbl[i]);

        // Halted for 10 cycles with flush pulses: bubble every edge, stall stays high
        for (int i = 0; i < 10; i++)
            apply(mk(0, i[0], 1, 16'h0123, 16'h0050, 1,1, 0,16'h0000,16'h0000,16'h0000,
                     5'b00000, 1, 1));

        for (int i = na; i < tbl.size(); i++) apply(tbl[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
